layer_sequencer: RTL and testbench

Control sequencer that time-shares one multiply-accumulate (MAC) datapath across every neuron of a fully connected layer. On `start` it walks neurons and inputs in order. For each step it issues input-register and weight addresses and MAC strobes, then writes each finished neuron into the output register bank. It sits between the layer's input/weight storage and the shared MAC unit plus its clearable output flip-flop bank.

---
 rtl/nn_seq_pkg.sv | 21 ++
 rtl/wrap_counter.sv | 18 +
 rtl/layer_sequencer.sv | 71 +++++++
 tb/tb_layer_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: state type and sizing helpers for layer_sequencer.
// Defining SEQ_BIAS_EN adds the BIAS state.
package nn_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
`ifdef SEQ_BIAS_EN
    S_BIAS,
`endif
    S_WRITE,
    S_DONE
  } seq_state_t;
  function automatic int clog2c(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Bias words sit directly after the N_IN*N_OUT weight block
  function automatic int bias_base(input int n_in, input int n_out);
    return n_in * n_out;
  endfunction
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MOD counter with enable, sync clear, async clr and terminal-count flag.
module wrap_counter #(
  parameter int MOD = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sclr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(MOD - 1);
  always_ff @(posedge clk or posedge clr)
    if (clr) cnt <= '0;
    else if (sclr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: time-shares one MAC across all neurons of a fully connected layer.
// Defining SEQ_BIAS_EN adds a per-neuron bias accumulate step.
module layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int XW    = clog2c(N_IN),
  parameter int OW    = clog2c(N_OUT),
  parameter int WAW   = clog2c(N_IN * N_OUT + N_OUT)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           abort,
  input  logic           in_valid,
  output logic           busy,
  output logic           done,
  output logic [XW-1:0]  x_idx,
  output logic [WAW-1:0] w_addr,
  output logic           mac_clr,
  output logic           mac_en,
  output logic           bias_en,
  output logic           out_we,
  output logic [OW-1:0]  out_idx
);
  seq_state_t state;
  logic [XW-1:0] i;
  logic [OW-1:0] j;
  logic i_tc, j_tc, kill;
  logic [WAW-1:0] acc_addr;
  assign kill = abort && state != S_IDLE;
  wrap_counter #(.MOD(N_IN), .W(XW)) u_i (
    .clk(clk), .clr(clr), .sclr(kill), .en(state == S_ACCUM && in_valid), .cnt(i), .tc(i_tc)
  );
  wrap_counter #(.MOD(N_OUT), .W(OW)) u_j (
    .clk(clk), .clr(clr), .sclr(kill), .en(state == S_WRITE), .cnt(j), .tc(j_tc)
  );
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= S_IDLE;
    else if (kill) state <= S_IDLE;
    else
      case (state)
        S_IDLE:  if (start) state <= S_CLEAR;
        S_CLEAR: state <= S_ACCUM;
`ifdef SEQ_BIAS_EN
        S_ACCUM: if (in_valid && i_tc) state <= S_BIAS;
        S_BIAS:  if (in_valid) state <= S_WRITE;
`else
        S_ACCUM: if (in_valid && i_tc) state <= S_WRITE;
`endif
        S_WRITE: state <= j_tc ? S_DONE : S_CLEAR;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
  assign acc_addr = WAW'(int'(j) * N_IN + int'(i));
  assign busy     = state != S_IDLE;
  assign done     = state == S_DONE;
  assign mac_clr  = state == S_CLEAR;
  assign mac_en   = state == S_ACCUM && in_valid;
  assign out_we   = state == S_WRITE;
  assign out_idx  = j;
  assign x_idx    = i;
`ifdef SEQ_BIAS_EN
  assign bias_en  = state == S_BIAS && in_valid;
  assign w_addr   = state == S_BIAS ? WAW'(bias_base(N_IN, N_OUT) + int'(j)) : acc_addr;
`else
  assign bias_en  = 1'b0;
  assign w_addr   = acc_addr;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of layer_sequencer (N_IN=4, N_OUT=3).
// Expected latencies follow SEQ_BIAS_EN when the bench is built with it.
module tb_layer_sequencer;
  localparam int N_IN = 4;
  localparam int N_OUT = 3;
`ifdef SEQ_BIAS_EN
  localparam int PER = N_IN + 3;
  localparam int NB = N_OUT;
`else
  localparam int PER = N_IN + 2;
  localparam int NB = 0;
`endif
  localparam int LAT = N_OUT * PER + 1;
  localparam int OFF = 100;
  localparam int LIMIT = 40;
  logic clk = 0, clr = 1, start = 0, abort = 0, in_valid = 1;
  logic busy, done, mac_clr, mac_en, bias_en, out_we;
  logic [1:0] x_idx, out_idx;
  logic [3:0] w_addr;
  int checks = 0, errors = 0;
  int done_at, we_cnt, mac_cnt, bias_cnt, bias_pre, n2;
  int we_idx[8];
  int mac_addr[16];
  int bias_addr[4];
  logic first_clr, pb;

  layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .in_valid(in_valid),
    .busy(busy), .done(done), .x_idx(x_idx), .w_addr(w_addr), .mac_clr(mac_clr),
    .mac_en(mac_en), .bias_en(bias_en), .out_we(out_we), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy, done, mac_clr, mac_en, bias_en, out_we, x_idx, w_addr, out_idx}, 0);
  endtask

  // One pass from IDLE; n counts negedges after the edge that samples start
  task automatic pass(input int stall_n, input int abort_n, input int clr_n, input int busy_n);
    done_at = 0; we_cnt = 0; mac_cnt = 0; bias_cnt = 0; bias_pre = 0; pb = 0; first_clr = 0;
    start = 1;
    tick;
    start = 0;
    for (int n = 1; n <= LIMIT; n++) begin
      in_valid = (n == stall_n || n == stall_n + 1) ? 1'b0 : 1'b1;
      start = (n >= busy_n && n < busy_n + 3);
      abort = (n == abort_n);
      if (n == clr_n) begin
        #2 clr = 1;
        #1 chk_zero("clr_async_zero");
        clr = 0;
      end
      #1;
      if (n == 1) first_clr = mac_clr;
      if (n == stall_n || n == stall_n + 1) begin
        chk("stall_x_idx", x_idx, 2);
        chk("stall_w_addr", w_addr, 6);
        chk("stall_mac_en", mac_en, 0);
      end
      if (n == abort_n + 1) chk("abort_busy", busy, 0);
      if (mac_en && mac_cnt < 16) mac_addr[mac_cnt++] = w_addr;
      if (bias_en && bias_cnt < 4) bias_addr[bias_cnt++] = w_addr;
      if (out_we) begin
        if (we_cnt < 8) we_idx[we_cnt] = out_idx;
        we_cnt++;
        if (pb) bias_pre++;
      end
      pb = bias_en;
      if (done) begin
        done_at = n;
        break;
      end
      tick;
    end
    start = 0; abort = 0; in_valid = 1;
    tick;
  endtask

  task automatic chk_full(input string tag, input int lat);
    chk({tag, "_done_at"}, done_at, lat);
    chk({tag, "_we_cnt"}, we_cnt, N_OUT);
    for (int k = 0; k < N_OUT; k++) chk({tag, "_out_idx"}, we_idx[k], k);
    chk({tag, "_mac_cnt"}, mac_cnt, N_IN * N_OUT);
    for (int k = 0; k < N_IN * N_OUT; k++) chk({tag, "_w_addr"}, mac_addr[k], k);
    chk({tag, "_bias_cnt"}, bias_cnt, NB);
    chk({tag, "_bias_pre_we"}, bias_pre, NB);
    for (int k = 0; k < NB; k++) chk({tag, "_bias_addr"}, bias_addr[k], N_IN * N_OUT + k);
  endtask

  initial begin
    @(negedge clk);
    #1 chk_zero("reset_zero");
    @(negedge clk);
    clr = 0;
    tick;
    chk_zero("idle_zero");
    pass(OFF, OFF, OFF, OFF);
    chk_full("plain", LAT);
    chk("plain_first_mac_clr", first_clr, 1);
    pass(PER + 4, OFF, OFF, OFF);
    chk_full("stall", LAT + 2);
    pass(OFF, PER + 3, OFF, OFF);
    chk("abort_done_at", done_at, 0);
    chk("abort_we_cnt", we_cnt, 1);
    chk_zero("abort_idle_zero");
    pass(OFF, OFF, 8, OFF);
    chk("clr_done_at", done_at, 0);
    pass(OFF, OFF, OFF, OFF);
    chk_full("after_clr", LAT);
    pass(OFF, OFF, OFF, 5);
    chk_full("busy_start", LAT);
    start = 1;
    tick;
    start = 0;
    chk("b2b_mac_clr", mac_clr, 1);
    chk("b2b_busy", busy, 1);
    n2 = 1;
    while (!done && n2 < LIMIT) begin
      tick;
      n2++;
    end
    chk("b2b_done_at", n2, LAT);
    tick;
    chk_zero("final_idle_zero");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
